// File: rtl/div_p3_pkg.sv
// Shared definitions for the FP divider back-end: FSM encoding, iteration
// length and IEEE-754 single-precision constants.
package fp_div_pkg;

    // Quotient bits per division: 1 integer + 23 fraction + 2 normalize/guard
    localparam int QBITS = 26;

    // Largest biased exponent; reaching it means the result is infinite
    localparam int EXP_MAX = 255;

    // Magnitude bits of +/-infinity (sign is prepended separately)
    localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIV   = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/div_p3_if.sv
// Operand/result handshake bundle between the divider normalization stage,
// this back-end stage and the FPU writeback.
interface div_p3_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 9
);
    logic              in_valid;
    logic              in_ready;
    logic              sign_in;
    logic [EXP_W-1:0]  exp_in;
    logic [MANT_W-1:0] mant_a_in;
    logic [MANT_W-1:0] mant_b_in;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       result;
    logic              overflow;
    logic              underflow;
    logic              inexact;

    // The divider stage itself
    modport slave (
        input  in_valid, sign_in, exp_in, mant_a_in, mant_b_in, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );

    // Whoever feeds operands and consumes results
    modport master (
        output in_valid, sign_in, exp_in, mant_a_in, mant_b_in, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/div_p3_rne.sv
// Combinational normalize, round-to-nearest-even and IEEE-754 single pack
// of a raw restoring-division quotient.
module div_rne_pack #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 9,
    parameter int QBITS  = fp_div_pkg::QBITS
) (
    input  logic [QBITS-1:0] i_q,
    input  logic             i_rem_nz,
    input  logic [EXP_W-1:0] i_exp,
    input  logic             i_sign,
    output logic [31:0]      o_result,
    output logic             o_overflow,
    output logic             o_underflow,
    output logic             o_inexact
);
    import fp_div_pkg::*;

    localparam logic signed [EXP_W:0] E_ONE  = (EXP_W+1)'(1);
    localparam logic signed [EXP_W:0] E_ZERO = '0;
    localparam logic signed [EXP_W:0] E_MAX  = (EXP_W+1)'(EXP_MAX);

    logic                    w_hi;
    logic [MANT_W-2:0]       w_frac;
    logic                    w_g;
    logic                    w_s;
    logic signed [EXP_W:0]   w_exp_ext;
    logic signed [EXP_W:0]   w_e_norm;
    logic                    w_round_up;
    logic [MANT_W-1:0]       w_frac_rnd;
    logic                    w_carry;
    logic signed [EXP_W:0]   w_e_fin;
    logic                    w_ovf;
    logic                    w_unf;

    // Quotient lies in (0.5, 2): the top bit picks which window holds the
    // mantissa. The hidden bit is implied, so only the fraction is kept.
    assign w_hi      = i_q[QBITS-1];
    assign w_frac    = w_hi ? i_q[QBITS-2:2] : i_q[QBITS-3:1];
    assign w_g       = w_hi ? i_q[1] : i_q[0];
    assign w_s       = w_hi ? (i_q[0] | i_rem_nz) : i_rem_nz;
    assign w_exp_ext = {i_exp[EXP_W-1], i_exp};
    assign w_e_norm  = w_hi ? w_exp_ext : (w_exp_ext - E_ONE);

    // A carry out of the fraction means the mantissa reached 2.0; the
    // fraction bits are then already zero, i.e. 1.0 with exponent bumped.
    assign w_round_up = w_g & (w_s | w_frac[0]);
    assign w_frac_rnd = {1'b0, w_frac} + {{(MANT_W-1){1'b0}}, w_round_up};
    assign w_carry    = w_frac_rnd[MANT_W-1];
    assign w_e_fin    = w_carry ? (w_e_norm + E_ONE) : w_e_norm;

    assign w_ovf = (w_e_fin >= E_MAX);
    assign w_unf = (w_e_fin <= E_ZERO);

    // Final packing with saturation to infinity or flush to zero
    always_comb begin
        o_result    = {i_sign, w_e_fin[7:0], w_frac_rnd[MANT_W-2:0]};
        o_overflow  = 1'b0;
        o_underflow = 1'b0;
        o_inexact   = w_g | w_s;
        if (w_ovf) begin
            o_result   = {i_sign, FP_INF_MAG};
            o_overflow = 1'b1;
            o_inexact  = 1'b1;
        end else if (w_unf) begin
            o_result    = {i_sign, 31'h0};
            o_underflow = 1'b1;
            o_inexact   = 1'b1;
        end
    end

endmodule

// File: rtl/div_p3.sv
// Back-end stage of the pipelined single-precision FP divider: iterative
// restoring mantissa division followed by normalize/round/pack.
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   IDLE     | ready for operands; accept latches them and clears q/R
//   DIV      | one quotient bit per cycle, MSB first, QBITS cycles
//   ROUND    | register packed result and flags
//   DONE     | result valid and held until the consumer takes it
module div_p3 #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 9,
    parameter int QBITS  = fp_div_pkg::QBITS
) (
    input  logic    clk,
    input  logic    rst_n,
    div_p3_if.slave bus
);
    import fp_div_pkg::*;

    localparam int CNT_W = $clog2(QBITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QBITS - 1);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_DIV   = ST_DIV;
    localparam logic [1:0] S_ROUND = ST_ROUND;
    localparam logic [1:0] S_DONE  = ST_DONE;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [MANT_W:0]   r_rem;
    logic [MANT_W-1:0] r_b;
    logic [QBITS-1:0]  r_q;
    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [31:0]       r_result;
    logic              r_ovf;
    logic              r_unf;
    logic              r_inx;

    logic              w_accept;
    logic              w_ge;
    logic [MANT_W-1:0] w_diff;
    logic [MANT_W:0]   w_rem_nxt;
    logic [31:0]       w_pack_result;
    logic              w_pack_ovf;
    logic              w_pack_unf;
    logic              w_pack_inx;

    assign w_accept = (r_state == S_IDLE) && r_in_ready && bus.in_valid;

    // Restoring step. R stays below 2B, so when R >= B the difference fits
    // in MANT_W bits and the left shift never loses a set bit.
    assign w_ge      = (r_rem >= {1'b0, r_b});
    assign w_diff    = r_rem[MANT_W-1:0] - r_b;
    assign w_rem_nxt = w_ge ? {w_diff, 1'b0} : {r_rem[MANT_W-1:0], 1'b0};

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_DIV;
            S_DIV:   if (r_cnt == CNT_LAST) w_state_nxt = S_ROUND;
            S_ROUND: w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register; in_ready is registered so it stays low during reset
    // and rises together with the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == S_IDLE);
        end
    end

    // Operand latch and division iteration datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_b    <= '0;
            r_q    <= '0;
            r_sign <= 1'b0;
            r_exp  <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_rem  <= {1'b0, bus.mant_a_in};
            r_b    <= bus.mant_b_in;
            r_q    <= '0;
            r_sign <= bus.sign_in;
            r_exp  <= bus.exp_in;
        end else if (r_state == S_DIV) begin
            r_cnt  <= r_cnt + 1'b1;
            r_rem  <= w_rem_nxt;
            r_q    <= {r_q[QBITS-2:0], w_ge};
        end
    end

    div_rne_pack #(
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W),
        .QBITS  (QBITS)
    ) u_rne (
        .i_q         (r_q),
        .i_rem_nz    (|r_rem),
        .i_exp       (r_exp),
        .i_sign      (r_sign),
        .o_result    (w_pack_result),
        .o_overflow  (w_pack_ovf),
        .o_underflow (w_pack_unf),
        .o_inexact   (w_pack_inx)
    );

    // Result registers: loaded in ROUND, held through DONE until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_inx       <= 1'b0;
        end else if (r_state == S_ROUND) begin
            r_out_valid <= 1'b1;
            r_result    <= w_pack_result;
            r_ovf       <= w_pack_ovf;
            r_unf       <= w_pack_unf;
            r_inx       <= w_pack_inx;
        end else if ((r_state == S_DONE) && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.inexact   = r_inx;

endmodule

// File: tb/tb_div_p3.sv
// Self-checking bench for div_p3: table of directed vectors plus random
// operands against a long-division reference, scoreboard queue, and
// hand-written backpressure and mid-operation reset sequences.
module tb_div_p3;

    typedef struct {
        logic        sign;
        logic [8:0]  exp;
        logic [23:0] a;
        logic [23:0] b;
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_p3_if bus ();

    div_p3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vec_t vecs[$];
    vec_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic [8:0] e, input logic [23:0] a,
                                input logic [23:0] b, input logic [31:0] r,
                                input logic ov, input logic uf, input logic ix);
        vec_t v;
        v.sign = s; v.exp = e; v.a = a; v.b = b;
        v.res = r; v.ovf = ov; v.unf = uf; v.inx = ix;
        return v;
    endfunction

    // Reference: exact integer quotient a*2^25/b, then IEEE RNE
    function automatic vec_t model(input logic s, input logic [8:0] e,
                                   input logic [23:0] a, input logic [23:0] b);
        vec_t        v;
        logic [63:0] num, quo, rm;
        logic [25:0] q;
        logic [23:0] m;
        logic [24:0] mr;
        logic        g, st, up;
        int          ee;
        num = {15'b0, a, 25'b0};
        quo = num / {40'b0, b};
        rm  = num % {40'b0, b};
        q   = quo[25:0];
        ee  = int'($signed(e));
        if (q[25]) begin
            m = q[25:2]; g = q[1]; st = q[0] | (rm != 0);
        end else begin
            m = q[24:1]; g = q[0]; st = (rm != 0); ee = ee - 1;
        end
        up = g & (st | m[0]);
        mr = {1'b0, m} + 25'(up);
        if (mr[24]) begin
            m = 24'h800000; ee = ee + 1;
        end else begin
            m = mr[23:0];
        end
        v = mk(s, e, a, b, 32'h0, 1'b0, 1'b0, g | st);
        if (ee >= 255) begin
            v.res = {s, 8'hFF, 23'h0}; v.ovf = 1'b1; v.inx = 1'b1;
        end else if (ee <= 0) begin
            v.res = {s, 31'h0}; v.unf = 1'b1; v.inx = 1'b1;
        end else begin
            v.res = {s, 8'(ee), m[22:0]};
        end
        return v;
    endfunction

    // Drive one operation from a negedge, check latency and result, optionally
    // hold out_ready low for 'hold' cycles after out_valid.
    task automatic run_op(input vec_t v, input int hold);
        int   w;
        int   cyc;
        vec_t e;
        logic [31:0] held;
        w = 0;
        while (bus.in_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_wait", 32'(w < 50), 32'd1);
        bus.in_valid  = 1'b1;
        bus.sign_in   = v.sign;
        bus.exp_in    = v.exp;
        bus.mant_a_in = v.a;
        bus.mant_b_in = v.b;
        sbq.push_back(v);
        @(posedge clk);
        @(negedge clk);
        check("in_ready_busy", 32'(bus.in_ready), 32'd0);
        // Garbage on the input side while busy must be ignored
        bus.in_valid  = 1'b1;
        bus.sign_in   = 1'($urandom());
        bus.exp_in    = 9'($urandom());
        bus.mant_a_in = 24'h800000 | 24'($urandom());
        bus.mant_b_in = 24'h800000 | 24'($urandom());
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'd27);
        if (hold > 0) bus.out_ready = 1'b0;
        if (sbq.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sbq.pop_front();
            check("result", bus.result, e.res);
            check("overflow", 32'(bus.overflow), 32'(e.ovf));
            check("underflow", 32'(bus.underflow), 32'(e.unf));
            check("inexact", 32'(bus.inexact), 32'(e.inx));
        end
        held = bus.result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_result", bus.result, held);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_done", 32'(bus.in_ready), 32'd1);
        check("valid_after_done", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sign_in   = 1'b0;
        bus.exp_in    = '0;
        bus.mant_a_in = '0;
        bus.mant_b_in = '0;
        bus.out_ready = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_flags", {29'd0, bus.overflow, bus.underflow, bus.inexact}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 32'(bus.in_ready), 32'd1);

        //               sign  exp      mant_a       mant_b       result        ov    uf    ix
        vecs.push_back(mk(1'b0, 9'd128, 24'hC00000, 24'hC00000, 32'h40000000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 9'd126, 24'h800000, 24'hC00000, 32'h3EAAAAAB, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 9'd127, 24'h800000, 24'hC00000, 32'h3F2AAAAB, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 9'd255, 24'h800000, 24'h800000, 32'hFF800000, 1'b1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 9'd1,   24'h800000, 24'hC00000, 32'h00000000, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 9'd127, 24'hFFFFFF, 24'h800000, 32'hBFFFFFFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 9'd254, 24'hFFFFFF, 24'h800000, 32'h7F7FFFFF, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 9'd255, 24'h800000, 24'hC00000, 32'h7F2AAAAB, 1'b0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 9'd0,   24'h800000, 24'h800000, 32'h80000000, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 9'd1,   24'h800000, 24'h800000, 32'h00800000, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 9'h1FB, 24'hC00000, 24'hC00000, 32'h00000000, 1'b0, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 9'd129, 24'hA00000, 24'hC00000, 32'h40555555, 1'b0, 1'b0, 1'b1));

        for (int i = 0; i < vecs.size(); i++) run_op(vecs[i], 0);

        // Backpressure: result held, in_ready low, then one-cycle return
        run_op(mk(1'b0, 9'd128, 24'hC00000, 24'hC00000, 32'h40000000, 1'b0, 1'b0, 1'b0), 5);

        for (int i = 0; i < 8; i++) begin
            run_op(model(1'($urandom()), 9'($urandom_range(20, 240)),
                         24'h800000 | 24'($urandom()), 24'h800000 | 24'($urandom())), 0);
        end

        // Reset during DIV aborts the operation with no output
        bus.in_valid  = 1'b1;
        bus.sign_in   = 1'b0;
        bus.exp_in    = 9'd128;
        bus.mant_a_in = 24'hC00000;
        bus.mant_b_in = 24'hC00000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_result", bus.result, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_release", 32'(bus.in_ready), 32'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        check("midrst_no_output", 32'(seen), 32'd0);
        run_op(mk(1'b0, 9'd126, 24'h800000, 24'hC00000, 32'h3EAAAAAB, 1'b0, 1'b0, 1'b1), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
